hazard_ctrl: RTL and testbench

- Central hazard and sequencing controller for the 5-stage MIPS pipeline.
- Drives stall/flush controls into the IF/ID, ID/EX, EX/MEM and MEM/WB registers and selects ALU operand forwarding.
- Handshakes multi-cycle data-memory accesses; branches resolve in MEM (PCSrcM = BranchM & ZeroM).
- Keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

---
 rtl/hazard_ctrl_pkg.sv | 33 +++
 rtl/hazard_ctrl_forward_unit.sv | 21 ++
 rtl/hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_hazard_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// Forward-select codes, controller state encoding and the register-zero guard.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrlState_t;

  // The MEM stage is the younger producer, so it wins over WB.
  function automatic logic [1:0] fwdSel(
    input logic [4:0] srcReg,
    input logic       regWriteM,
    input logic [4:0] writeRegM,
    input logic       regWriteW,
    input logic [4:0] writeRegW
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (regWriteM && (writeRegM != REG_ZERO) && (writeRegM == srcReg))
      sel = FWD_MEM;
    else if (regWriteW && (writeRegW != REG_ZERO) && (writeRegW == srcReg))
      sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// Combinational ALU operand forwarding for both execute-stage sources.
// One instance resolves the A (rs) and B (rt) selects from the same producers.
module forward_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeRegM,
  input  logic [4:0] writeRegW,
  input  logic       regWriteM,
  input  logic       regWriteW,
  output logic [1:0] forwardA,
  output logic [1:0] forwardB
);

  always_comb begin
    forwardA = fwdSel(rsE, regWriteM, writeRegM, regWriteW, writeRegW);
    forwardB = fwdSel(rtE, regWriteM, writeRegM, regWriteW, writeRegW);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: stalls, flushes,
// operand forwarding, data-memory wait handshake, stall counter and timeout flag.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             regWriteE,
  input  logic             regWriteM,
  input  logic             regWriteW,
  input  logic             MemToRegE,
  input  logic             MemToRegM,
  input  logic             MemWriteM,
  input  logic             BranchM,
  input  logic             ZeroM,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_err
);

  localparam int WCNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  ctrlState_t        state;
  logic [WCNT_W-1:0] waitCnt;
  logic [CNT_W-1:0]  stallCnt;
  logic              memErr;

  logic       memM, branchTaken, loadUse, inWait;
  logic       branchAct, missRun, holdAll, loadUseAct, reqAct;
  logic [1:0] fwdA, fwdB;

  forward_unit uFwd (
    .rsE       (RsE),
    .rtE       (RtE),
    .writeRegM (WriteRegM),
    .writeRegW (WriteRegW),
    .regWriteM (regWriteM),
    .regWriteW (regWriteW),
    .forwardA  (fwdA),
    .forwardB  (fwdB)
  );

  always_comb begin
    memM        = MemToRegM | MemWriteM;
    branchTaken = BranchM & ZeroM;
    loadUse     = MemToRegE & regWriteE & (WriteRegE != REG_ZERO) &
                  ((WriteRegE == RsD) | (WriteRegE == RtD));
    inWait      = (state == MEM_WAIT);
    branchAct   = !inWait & branchTaken;
    reqAct      = inWait | (!inWait & memM & !branchTaken);
    // A miss in RUN already freezes every stage, which subsumes the load-use bubble.
    missRun     = !inWait & memM & !branchTaken & !dmem_ready;
    holdAll     = inWait | missRun;
    loadUseAct  = !inWait & !branchTaken & !missRun & loadUse;
  end

  // Everything is forced low while reset is held, including the async drop of dmem_req.
  always_comb begin
    dmem_req    = RST & reqAct;
    StallF      = RST & (holdAll | loadUseAct);
    StallD      = RST & (holdAll | loadUseAct);
    StallE      = RST & holdAll;
    StallM      = RST & holdAll;
    FlushD      = RST & branchAct;
    FlushE      = RST & (branchAct | loadUseAct);
    FlushM      = RST & branchAct;
    FlushW      = RST & holdAll;
    ForwardAE   = RST ? fwdA : FWD_RF;
    ForwardBE   = RST ? fwdB : FWD_RF;
    stall_count = stallCnt;
    mem_err     = memErr;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= RUN;
      waitCnt  <= '0;
      stallCnt <= '0;
      memErr   <= 1'b0;
    end else begin
      if (StallF && (stallCnt != {CNT_W{1'b1}}))
        stallCnt <= stallCnt + CNT_W'(1);

      case (state)
        RUN: begin
          waitCnt <= '0;
          if (missRun)
            state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state   <= RUN;
            waitCnt <= '0;
          end else begin
            if (waitCnt != WCNT_W'(WAIT_MAX))
              waitCnt <= waitCnt + WCNT_W'(1);
            // Counter is about to reach WAIT_MAX with the access still outstanding.
            if (waitCnt == WCNT_W'(WAIT_MAX - 1))
              memErr <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: reset, load-use, branch, memory wait, timeout, forwarding.
module tb_hazard_ctrl;

  logic        CLK;
  logic        RST;
  logic [4:0]  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic        regWriteE, regWriteM, regWriteW, MemToRegE, MemToRegM, MemWriteM;
  logic        BranchM, ZeroM, dmem_ready;
  logic        dmem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] stall_count;
  logic        mem_err;

  int nTests = 0;
  int nFail  = 0;

  hazard_ctrl #(.WAIT_MAX(4), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
    .MemToRegE(MemToRegE), .MemToRegM(MemToRegM), .MemWriteM(MemWriteM),
    .BranchM(BranchM), .ZeroM(ZeroM), .dmem_ready(dmem_ready),
    .dmem_req(dmem_req),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .stall_count(stall_count), .mem_err(mem_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clearInputs();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    regWriteE = 0; regWriteM = 0; regWriteW = 0;
    MemToRegE = 0; MemToRegM = 0; MemWriteM = 0;
    BranchM = 0; ZeroM = 0; dmem_ready = 0;
  endtask

  initial begin
    RST = 1'b0;
    clearInputs();
    // Reset held with a load, a taken branch, a load-use and a forward all pending
    MemToRegM = 1; BranchM = 1; ZeroM = 1;
    MemToRegE = 1; regWriteE = 1; WriteRegE = 8; RsD = 8;
    RsE = 5; regWriteM = 1; WriteRegM = 5;
    #2;
    checkVal("rst_ctrl", {dmem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW}, 0);
    checkVal("rst_fwd", {ForwardAE, ForwardBE}, 0);
    step();
    checkVal("rst_cnt", stall_count, 0);
    checkVal("rst_err", mem_err, 0);

    // Release reset with a zero-wait load in MEM
    clearInputs();
    MemToRegM = 1; dmem_ready = 1;
    RST = 1'b1;
    #1;
    checkVal("rel_req", dmem_req, 1);
    checkVal("rel_nostall", {StallF, StallD, StallE, StallM, FlushW}, 0);
    step();
    checkVal("zw_run", StallF, 0);
    clearInputs();

    // Load-use on rs
    MemToRegE = 1; regWriteE = 1; WriteRegE = 8; RsD = 8;
    #1;
    checkVal("lu_sfdfe", {StallF, StallD, FlushE}, 3'b111);
    checkVal("lu_other", {StallE, StallM, FlushD, FlushM, FlushW}, 0);
    checkVal("lu_cnt0", stall_count, 0);
    step();
    clearInputs();
    #1;
    checkVal("lu_cnt1", stall_count, 1);
    checkVal("lu_gone", StallF, 0);

    // Load-use on rt
    MemToRegE = 1; regWriteE = 1; WriteRegE = 9; RtD = 9; RsD = 3;
    #1;
    checkVal("lu_rt", {StallF, StallD, FlushE}, 3'b111);
    // Destination register zero never stalls
    WriteRegE = 0; RsD = 0; RtD = 0;
    #1;
    checkVal("lu_r0", {StallF, StallD, FlushE}, 0);
    step();
    checkVal("lu_r0_cnt", stall_count, 1);
    clearInputs();

    // Taken branch beats a simultaneous load-use
    BranchM = 1; ZeroM = 1;
    MemToRegE = 1; regWriteE = 1; WriteRegE = 8; RsD = 8;
    #1;
    checkVal("br_flush", {FlushD, FlushE, FlushM}, 3'b111);
    checkVal("br_nostall", {StallF, StallD, StallE, StallM, FlushW}, 0);
    // Branch with a load in MEM: no request
    MemToRegM = 1;
    #1;
    checkVal("br_noreq", dmem_req, 0);
    checkVal("br_mem_flush", {FlushD, FlushE, FlushM}, 3'b111);
    clearInputs();
    BranchM = 1; ZeroM = 0;
    #1;
    checkVal("br_nt", {FlushD, FlushE, FlushM}, 0);
    step();
    checkVal("br_cnt", stall_count, 1);
    clearInputs();

    // Memory wait: ready low 3 cycles then high
    MemToRegM = 1; dmem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dmem_ready = 1;
      #1;
      checkVal($sformatf("mw_req%0d", i), dmem_req, 1);
      checkVal($sformatf("mw_hold%0d", i), {StallF, StallD, StallE, StallM, FlushW}, 5'b11111);
      checkVal($sformatf("mw_fl%0d", i), {FlushD, FlushE, FlushM}, 0);
      step();
    end
    clearInputs();
    #1;
    checkVal("mw_run", {dmem_req, StallF}, 0);
    checkVal("mw_cnt", stall_count, 5);

    // Timeout with WAIT_MAX=4: cycle 0 is the RUN miss, cycles 1..5 in MEM_WAIT
    MemToRegM = 1; dmem_ready = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      checkVal($sformatf("to_err%0d", k), mem_err, (k >= 5) ? 1 : 0);
      step();
    end
    dmem_ready = 1;
    #1;
    checkVal("to_req", dmem_req, 1);
    step();
    clearInputs();
    #1;
    checkVal("to_sticky", mem_err, 1);
    checkVal("to_run", {dmem_req, StallF}, 0);
    checkVal("to_cnt", stall_count, 12);

    // Reset asserted mid-wait
    MemToRegM = 1; dmem_ready = 0;
    step();
    step();
    checkVal("rw_req", dmem_req, 1);
    #2;
    RST = 1'b0;
    #1;
    checkVal("rw_err", mem_err, 0);
    checkVal("rw_req0", dmem_req, 0);
    checkVal("rw_cnt", stall_count, 0);
    MemToRegM = 0;
    RST = 1'b1;
    #1;
    checkVal("rw_state", {dmem_req, StallF, StallE}, 0);
    step();

    // Forwarding
    RsE = 5; RtE = 5;
    regWriteM = 1; WriteRegM = 5; regWriteW = 1; WriteRegW = 5;
    #1;
    checkVal("fwd_mem", {ForwardAE, ForwardBE}, 4'b1010);
    regWriteM = 0;
    #1;
    checkVal("fwd_wb", {ForwardAE, ForwardBE}, 4'b0101);
    RsE = 0;
    #1;
    checkVal("fwd_r0", {ForwardAE, ForwardBE}, 4'b0001);
    RsE = 7; RtE = 5; regWriteM = 1; WriteRegM = 7;
    #1;
    checkVal("fwd_mix", {ForwardAE, ForwardBE}, 4'b1001);
    WriteRegW = 0; WriteRegM = 0;
    RsE = 0; RtE = 0;
    #1;
    checkVal("fwd_none", {ForwardAE, ForwardBE}, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
